// File: rtl/ff_exc_pkg.sv
// ff_exc_pkg: mode codes and FSM states shared by the FF excitation driver and its benches
package ff_exc_pkg;
   localparam logic [1:0] FF_SR = 2'd0, FF_JK = 2'd1, FF_D = 2'd2, FF_T = 2'd3;
   typedef enum logic [2:0] {INIT, INIT_CLK, INIT_CHK, IDLE, DRIVE, CLOCK, CHECK} state_t;
endpackage

// File: rtl/ff_excitation_lut.sv
// ff_excitation_lut: excitation table (mode, q, t) -> (a, b); SR/JK don't-cares driven 0
module ff_excitation_lut
   import ff_exc_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       q,
   input  logic       t,
   output logic       a,
   output logic       b
);
   always_comb begin
      a = (mode == FF_D) ? t : (mode == FF_T) ? q ^ t : ~q & t;
      b = (mode == FF_SR || mode == FF_JK) ? q & ~t : 1'b0;
   end
endmodule

// File: rtl/ff_excitation_driver.sv
// ff_excitation_driver: drives one FF vector per handshake, strobes its clock and checks Q/Qbar
module ff_excitation_driver
   import ff_exc_pkg::*;
#(
   parameter logic [1:0] MODE  = FF_SR,
   parameter int         CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             exc_a,
   output logic             exc_b,
   output logic             ff_clk,
   input  logic             ff_q,
   input  logic             ff_qbar,
   output logic             mismatch,
   output logic             illegal,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   state_t state, nxt;
   logic tgt_q, model_q, lut_a, lut_b, hit, bad_pair;
   ff_excitation_lut u_lut (.mode(MODE), .q(model_q), .t(tgt_q), .a(lut_a), .b(lut_b));
   always_ff @(posedge clk)
      state <= rst ? INIT : nxt;
   always_comb begin
      nxt = state;
      case (state)
         INIT:     nxt = INIT_CLK;
         INIT_CLK: nxt = INIT_CHK;
         INIT_CHK: nxt = IDLE;
         IDLE:     nxt = tgt_valid ? DRIVE : IDLE;
         DRIVE:    nxt = CLOCK;
         CLOCK:    nxt = CHECK;
         default:  nxt = IDLE;
      endcase
   end
   // init clears SR/JK through R/K; D loads 0; T is left alone and read back instead
   always_comb begin
      tgt_ready = state == IDLE;
      ff_clk    = state == INIT_CLK || state == CLOCK;
      exc_a     = (state inside {DRIVE, CLOCK, CHECK}) & lut_a;
      exc_b     = (state inside {DRIVE, CLOCK, CHECK}) ? lut_b :
                  (state inside {INIT, INIT_CLK, INIT_CHK}) & (MODE == FF_SR || MODE == FF_JK);
   end
   assign hit      = ff_q == tgt_q && ff_qbar == ~tgt_q;
   assign bad_pair = ff_q == ff_qbar;
   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_q    <= 1'b0;
         model_q  <= 1'b0;
         mismatch <= 1'b0;
         illegal  <= 1'b0;
         pass_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         mismatch <= 1'b0;
         if (tgt_valid && tgt_ready) tgt_q <= tgt_bit;
         if (state == INIT_CHK) begin
            model_q <= ff_q;
            if (bad_pair) illegal <= 1'b1;
         end
         if (state == CHECK) begin
            model_q <= tgt_q;
            if (hit) begin
               if (~&pass_cnt) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
               mismatch <= 1'b1;
               if (~&err_cnt) err_cnt <= err_cnt + CNT_W'(1);
               if (bad_pair) illegal <= 1'b1;
            end
         end
      end
   end
endmodule
